// File: rtl/alu_arbiter.sv
// alu_arbiter: one shared 32-bit logic/arith unit serving two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic last_grant, grant, accept;
  logic [2:0] op_q;
  logic [31:0] a_q, b_q, res_q, alu;
`ifdef ALU_ARB_RR_EN
  assign grant = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
`else
  assign grant = ~req0_valid;
`endif
  assign accept = !reset && state == IDLE && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  // last_grant doubles as the id of the transaction in flight, so it steers the response
  assign rsp0_valid = state == RESP && !last_grant;
  assign rsp1_valid = state == RESP && last_grant;
  assign rsp0_result = last_grant ? '0 : res_q;
  assign rsp1_result = last_grant ? res_q : '0;
  always_comb begin
    alu = '0;
    case (op_q)
      3'b000: alu = a_q & b_q;
      3'b001: alu = a_q | b_q;
      3'b010: alu = a_q ^ b_q;
      3'b011: alu = ~(a_q | b_q);
      3'b100: alu = a_q + b_q;
      3'b101: alu = a_q - b_q;
      3'b110: alu = {31'b0, $signed(a_q) < $signed(b_q)};
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_nxt = state == IDLE ? (accept ? EXEC : IDLE)
              : state == EXEC ? RESP
              : ((last_grant ? rsp1_ready : rsp0_ready) ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        op_q <= grant ? req1_op : req0_op;
        a_q <= grant ? req1_a : req0_a;
        b_q <= grant ? req1_b : req0_b;
      end
      if (state == EXEC) res_q <= alu;
    end
  end
endmodule
